// File: rtl/note_sequencer.sv
// Melody sequencer: steps a {note, duration} table at a divided tick rate
// and drives the wavetable note/play inputs.
module note_sequencer #(
    parameter int TICK_DIV  = 100000,
    parameter int SEQ_LEN   = 16,
    parameter int GAP_TICKS = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop_en,
    input  logic                       wr_en,
    input  logic [$clog2(SEQ_LEN)-1:0] wr_addr,
    input  logic [7:0]                 wr_note,
    input  logic [7:0]                 wr_dur,
    output logic [7:0]                 note,
    output logic                       play,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(SEQ_LEN)-1:0] step
);

    localparam int SW = $clog2(SEQ_LEN);
    localparam int TW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, LOAD, SOUND, GAP} state_t;

    state_t         state, state_d;
    logic [7:0]     tbl_note [SEQ_LEN];
    logic [7:0]     tbl_dur  [SEQ_LEN];
    logic [TW-1:0]  cnt, cnt_d;
    logic [7:0]     remain, remain_d;
    logic [SW-1:0]  step_d;
    logic [7:0]     note_d;
    logic           play_d, busy_d, done_d;
    logic           tick, adv, finish;
    logic [7:0]     cur_note, cur_dur;

    assign cur_note = tbl_note[step];
    assign cur_dur  = tbl_dur[step];
    assign tick     = (cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SEQ_LEN; i++) begin
                tbl_note[i] <= '0;
                tbl_dur[i]  <= '0;
            end
        end else if (wr_en) begin
            tbl_note[wr_addr] <= wr_note;
            tbl_dur[wr_addr]  <= wr_dur;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d  = state;
        step_d   = step;
        note_d   = note;
        play_d   = play;
        done_d   = 1'b0;
        remain_d = remain;
        cnt_d    = '0;
        adv      = 1'b0;
        finish   = 1'b0;

        unique case (state)
            IDLE: begin
                play_d = 1'b0;
                if (start) begin
                    step_d  = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (cur_dur == 8'd0) begin
                    finish = 1'b1;
                end else begin
                    note_d   = cur_note;
                    play_d   = (cur_note != 8'hFF);
                    remain_d = cur_dur;
                    state_d  = SOUND;
                end
            end
            SOUND: begin
                cnt_d = tick ? '0 : cnt + TW'(1);
                if (tick) begin
                    if (remain != 8'd1) begin
                        remain_d = remain - 8'd1;
                    end else if (GAP_TICKS > 0) begin
                        play_d   = 1'b0;
                        remain_d = 8'(GAP_TICKS);
                        state_d  = GAP;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            GAP: begin
                play_d = 1'b0;
                cnt_d  = tick ? '0 : cnt + TW'(1);
                if (tick) begin
                    if (remain != 8'd1) remain_d = remain - 8'd1;
                    else                adv      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (adv) begin
            if (step == SW'(SEQ_LEN - 1)) begin
                finish = 1'b1;
            end else begin
                step_d  = step + SW'(1);
                state_d = LOAD;
            end
        end

        // End of table: restart from entry 0 only if not already there,
        // so an empty table cannot spin in LOAD.
        if (finish) begin
            if (loop_en && step != '0) begin
                step_d  = '0;
                state_d = LOAD;
            end else begin
                done_d  = 1'b1;
                play_d  = 1'b0;
                state_d = IDLE;
            end
        end

        if (stop) begin
            state_d = IDLE;
            step_d  = step;
            note_d  = note;
            play_d  = 1'b0;
            done_d  = 1'b0;
            cnt_d   = '0;
        end

        // busy covers the done cycle so it falls one cycle after the pulse
        busy_d = (state_d != IDLE) || done_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step   <= '0;
            note   <= '0;
            play   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            remain <= '0;
            cnt    <= '0;
        end else begin
            step   <= step_d;
            note   <= note_d;
            play   <= play_d;
            busy   <= busy_d;
            done   <= done_d;
            remain <= remain_d;
            cnt    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: entry-level expansion model of the melody
// timeline, compared every cycle under directed and random stimulus.
module tb_note_sequencer;

    localparam int TD  = 4;
    localparam int LEN = 4;
    localparam int G   = 1;

    localparam logic [1:0] K_RUN  = 2'd0;
    localparam logic [1:0] K_LOAD = 2'd1;
    localparam logic [1:0] K_END  = 2'd2;

    typedef struct packed {
        logic [7:0] note;
        logic       play;
        logic       busy;
        logic       done;
        logic [1:0] step;
        logic [1:0] kind;
    } item_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop_en = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [7:0] wr_note = '0;
    logic [7:0] wr_dur = '0;
    logic [7:0] note;
    logic       play;
    logic       busy;
    logic       done;
    logic [1:0] step;

    int n_tot = 0;
    int n_bad = 0;

    item_t      cur;
    item_t      plan[$];
    bit         m_act;
    logic [7:0] m_note [LEN];
    logic [7:0] m_dur  [LEN];

    note_sequencer #(
        .TICK_DIV (TD),
        .SEQ_LEN  (LEN),
        .GAP_TICKS(G)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .stop   (stop),
        .loop_en(loop_en),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_note(wr_note),
        .wr_dur (wr_dur),
        .note   (note),
        .play   (play),
        .busy   (busy),
        .done   (done),
        .step   (step)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic item_t mk(logic [7:0] n, logic p, logic d,
                                 logic [1:0] s, logic [1:0] k);
        item_t r;
        r.note = n;
        r.play = p;
        r.busy = 1'b1;
        r.done = d;
        r.step = s;
        r.kind = k;
        return r;
    endfunction

    // Expand the entry read by the LOAD cycle in cur into its full timeline:
    // dur*TD sounding cycles, G*TD gap cycles, then the next LOAD or the end.
    function automatic void expand();
        logic [1:0] idx;
        logic [7:0] n;
        logic [7:0] d;
        logic       lp;
        idx = cur.step;
        n   = m_note[idx];
        d   = m_dur[idx];
        if (d == 8'd0) begin
            if (loop_en && idx != 2'd0)
                plan.push_back(mk(cur.note, cur.play, 1'b0, 2'd0, K_LOAD));
            else
                plan.push_back(mk(cur.note, 1'b0, 1'b1, idx, K_END));
        end else begin
            for (int i = 0; i < int'(d) * TD; i++)
                plan.push_back(mk(n, n != 8'hFF, 1'b0, idx, K_RUN));
            for (int i = 0; i < G * TD; i++)
                plan.push_back(mk(n, 1'b0, 1'b0, idx, K_RUN));
            lp = (G > 0) ? 1'b0 : (n != 8'hFF);
            if (idx == 2'(LEN - 1)) begin
                if (loop_en) plan.push_back(mk(n, lp, 1'b0, 2'd0, K_LOAD));
                else         plan.push_back(mk(n, 1'b0, 1'b1, idx, K_END));
            end else begin
                plan.push_back(mk(n, lp, 1'b0, idx + 2'd1, K_LOAD));
            end
        end
    endfunction

    function automatic void mdl_reset();
        cur   = '0;
        m_act = 1'b0;
        plan.delete();
        for (int i = 0; i < LEN; i++) begin
            m_note[i] = '0;
            m_dur[i]  = '0;
        end
    endfunction

    task automatic mdl_step();
        if (stop) begin
            plan.delete();
            cur.play = 1'b0;
            cur.busy = 1'b0;
            cur.done = 1'b0;
            cur.kind = K_RUN;
            m_act    = 1'b0;
        end else if (!m_act) begin
            cur.done = 1'b0;
            cur.play = 1'b0;
            cur.kind = K_RUN;
            if (start) begin
                m_act    = 1'b1;
                cur.busy = 1'b1;
                cur.step = 2'd0;
                cur.kind = K_LOAD;
            end else begin
                cur.busy = 1'b0;
            end
        end else begin
            if (cur.kind == K_LOAD) expand();
            if (plan.size() == 0) begin
                chk("model_plan", 0, 1);
                m_act = 1'b0;
            end else begin
                cur = plan.pop_front();
                if (cur.kind == K_END) m_act = 1'b0;
            end
        end
        if (wr_en) begin
            m_note[wr_addr] = wr_note;
            m_dur[wr_addr]  = wr_dur;
        end
    endtask

    task automatic cmp_out();
        chk("note", 32'(note), 32'(cur.note));
        chk("play", 32'(play), 32'(cur.play));
        chk("busy", 32'(busy), 32'(cur.busy));
        chk("done", 32'(done), 32'(cur.done));
        chk("step", 32'(step), 32'(cur.step));
    endtask

    task automatic cyc();
        @(posedge clk);
        mdl_step();
        #1;
        cmp_out();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        mdl_reset();
        cmp_out();
        @(posedge clk);
        #1;
        cmp_out();
        rst = 1'b0;
    endtask

    task automatic wr(logic [1:0] a, logic [7:0] n, logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_note = n;
        wr_dur  = d;
        cyc();
        wr_en = 1'b0;
    endtask

    // Start pulse in cycle 0, run n cycles; report first done cycle,
    // number of done pulses and cycles with play high.
    task automatic play_run(int n, output int done_at, output int n_done,
                            output int n_play);
        done_at = -1;
        n_done  = 0;
        n_play  = 0;
        start   = 1'b1;
        for (int c = 1; c <= n; c++) begin
            cyc();
            start = 1'b0;
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = c;
            end
            if (play) n_play++;
        end
    endtask

    task automatic wait_for(string tag, int kind, int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            cyc();
            case (kind)
                0:       hit = (step == 2'd1) && play;
                1:       hit = (step == 2'd0);
                default: hit = play;
            endcase
        end
        chk(tag, 32'(hit), 1);
    endtask

    task automatic load_s2();
        wr(2'd0, 8'd60, 8'd2);
        wr(2'd1, 8'd62, 8'd1);
        wr(2'd2, 8'd0, 8'd0);
    endtask

    initial begin
        int da, nd, np;
        mdl_reset();

        // reset and idle
        do_reset();
        repeat (20) cyc();

        // two notes then end marker
        load_s2();
        play_run(30, da, nd, np);
        chk("s2_done_at", 32'(da), 24);
        chk("s2_done_n", 32'(nd), 1);
        chk("s2_play_n", 32'(np), 12);

        // rest entry
        wr(2'd0, 8'hFF, 8'd2);
        wr(2'd1, 8'd64, 8'd1);
        play_run(30, da, nd, np);
        chk("s3_done_at", 32'(da), 24);
        chk("s3_done_n", 32'(nd), 1);
        chk("s3_play_n", 32'(np), 4);

        // looping, then stop mid-sound
        load_s2();
        loop_en = 1'b1;
        play_run(75, da, nd, np);
        chk("s4_done_n", 32'(nd), 0);
        wait_for("s4_wait_play", 2, 40);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("s4_stop_busy", 32'(busy), 0);
        chk("s4_stop_play", 32'(play), 0);
        chk("s4_stop_done", 32'(done), 0);
        repeat (5) cyc();

        // empty table with loop enabled
        do_reset();
        loop_en = 1'b1;
        play_run(10, da, nd, np);
        chk("s5_done_at", 32'(da), 2);
        chk("s5_done_n", 32'(nd), 1);
        chk("s5_busy", 32'(busy), 0);

        // start+stop together, restart ignored, live table edit
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        chk("s6_ss_busy", 32'(busy), 0);
        load_s2();
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (5) cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("s6_restart_step", 32'(step), 0);
        wait_for("s6_wait_e1", 0, 40);
        wr(2'd1, 8'd67, 8'd1);
        wait_for("s6_wait_e0", 1, 40);
        wait_for("s6_wait_e1b", 0, 40);
        chk("s6_new_note", 32'(note), 67);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        cyc();

        // randomized stimulus
        for (int i = 0; i < LEN; i++)
            wr(2'(i), ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom),
               ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 3)));
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) do_reset();
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 149) == 0);
            wr_en = ($urandom_range(0, 19) == 0);
            wr_addr = 2'($urandom);
            wr_note = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom);
            wr_dur  = ($urandom_range(0, 7) == 0) ? 8'd0
                                                  : 8'($urandom_range(1, 3));
            if (!m_act && $urandom_range(0, 9) == 0)
                loop_en = 1'($urandom);
            cyc();
        end
        start = 1'b0;
        stop  = 1'b0;
        wr_en = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
